cam_stream_gen: RTL and testbench

Synthetic OV7670-style camera source for bring-up and bench loopback of the capture path without a physical sensor. Drives vsync/href/8-bit byte stream on pclk, two bytes per RGB444 pixel, with programmable frame timing and built-in test patterns. Its outputs connect directly in place of the sensor pins feeding the memory controller's capture FSM.

---
 rtl/cam_stream_gen.sv | 197 +++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: synthetic OV7670-style camera source.
// Emits vsync/href/8-bit data on pclk with RGB444 pixels sent as two bytes:
// {4'b0000, R} on even columns and {G, B} on odd columns. Frame timing and
// test-pattern choice are parameterised and latched once per frame.

module cam_stream_gen #(
  parameter int H_ACTIVE  = 640,  // active pixels per line (multiple of 8)
  parameter int H_BLANK   = 288,  // href-low cycles per line
  parameter int V_ACTIVE  = 480,  // active lines per frame
  parameter int VSYNC_LEN = 3,    // lines with vsync high
  parameter int V_BACK    = 17,   // blank lines after vsync
  parameter int V_FRONT   = 10    // blank lines after the last active line
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  // Line and frame geometry.
  localparam int LINE_CYC = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int MAX_A    = (V_ACTIVE > VSYNC_LEN) ? V_ACTIVE : VSYNC_LEN;
  localparam int MAX_B    = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int LINE_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  // Counter widths cover the largest value each counter reaches.
  localparam int COL_W  = (LINE_CYC > 1) ? $clog2(LINE_CYC) : 1;
  localparam int LINE_W = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(LINE_CYC - 1);
  localparam logic [COL_W-1:0]  HREF_END    = COL_W'(2 * H_ACTIVE);
  localparam logic [LINE_W-1:0] VSYNC_LAST  = LINE_W'(VSYNC_LEN - 1);
  localparam logic [LINE_W-1:0] BACK_LAST   = LINE_W'(V_BACK - 1);
  localparam logic [LINE_W-1:0] ACTIVE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] FRONT_LAST  = LINE_W'(V_FRONT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  // Current position: state/col_cnt/line_cnt describe the cycle being output.
  state_t            state;
  logic [COL_W-1:0]  col_cnt;
  logic [LINE_W-1:0] line_cnt;

  // Position of the cycle that follows the next clock edge.
  state_t            nxt_state;
  logic [COL_W-1:0]  nxt_col;
  logic [LINE_W-1:0] nxt_line;
  logic [LINE_W-1:0] phase_last;
  logic              start_frame;
  logic              href_nxt;
  logic              frame_end_nxt;

  // Frame-stable copies of the pattern controls.
  logic [1:0]  pat_q;
  logic [11:0] rgb_q;

  // Pixel generation for the next cycle.
  logic [15:0] px_x;
  logic [15:0] px_y;
  logic [2:0]  bar_idx;
  logic [11:0] pix_rgb;
  logic [7:0]  pix_byte;

  // Advance the raster position by one pclk and pick the next phase.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    nxt_state   = state;
    nxt_col     = col_cnt;
    nxt_line    = line_cnt;
    start_frame = 1'b0;

    case (state)
      ST_VSYNC:  phase_last = VSYNC_LAST;
      ST_VBACK:  phase_last = BACK_LAST;
      ST_ACTIVE: phase_last = ACTIVE_LAST;
      ST_VFRONT: phase_last = FRONT_LAST;
      default:   phase_last = '0;
    endcase

    if (state == ST_IDLE) begin
      nxt_col  = '0;
      nxt_line = '0;
      if (enable) begin
        nxt_state   = ST_VSYNC;
        start_frame = 1'b1;
      end
    end else if (col_cnt != COL_LAST) begin
      nxt_col = col_cnt + 1'b1;
    end else begin
      nxt_col = '0;
      if (line_cnt != phase_last) begin
        nxt_line = line_cnt + 1'b1;
      end else begin
        nxt_line = '0;
        case (state)
          ST_VSYNC:  nxt_state = ST_VBACK;
          ST_VBACK:  nxt_state = ST_ACTIVE;
          ST_ACTIVE: nxt_state = ST_VFRONT;
          ST_VFRONT: begin
            // Back-to-back frames restart vsync with no idle gap.
            if (enable) begin
              nxt_state   = ST_VSYNC;
              start_frame = 1'b1;
            end else begin
              nxt_state = ST_IDLE;
            end
          end
          default:   nxt_state = ST_IDLE;
        endcase
      end
    end

    href_nxt      = (nxt_state == ST_ACTIVE) && (nxt_col < HREF_END);
    frame_end_nxt = (nxt_state == ST_VFRONT) && (nxt_line == FRONT_LAST) &&
                    (nxt_col == COL_LAST);
  end

  // Build the RGB444 pixel and select the byte for the next cycle.
  always_comb begin
    px_x    = 16'(nxt_col >> 1);
    px_y    = 16'(nxt_line);
    bar_idx = 3'(px_x / 16'(BAR_W));
    pix_rgb = '0;

    case (pat_q)
      2'd0: begin
        case (bar_idx)
          3'd0:    pix_rgb = 12'hFFF;
          3'd1:    pix_rgb = 12'hFF0;
          3'd2:    pix_rgb = 12'h0FF;
          3'd3:    pix_rgb = 12'h0F0;
          3'd4:    pix_rgb = 12'hF0F;
          3'd5:    pix_rgb = 12'hF00;
          3'd6:    pix_rgb = 12'h00F;
          default: pix_rgb = 12'h000;
        endcase
      end
      2'd1:    pix_rgb = {4'(px_x >> 2), 4'(px_y >> 2), frame_cnt[3:0]};
      2'd2:    pix_rgb = rgb_q;
      default: pix_rgb = (px_x[5] ^ px_y[5] ^ frame_cnt[0]) ? 12'hFFF : 12'h000;
    endcase

    pix_byte = nxt_col[0] ? pix_rgb[7:0] : {4'b0000, pix_rgb[11:8]};
  end

  // Frame FSM and registered sensor outputs, all aligned to the same edge.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      col_cnt    <= '0;
      line_cnt   <= '0;
      pat_q      <= '0;
      rgb_q      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state    <= nxt_state;
      col_cnt  <= nxt_col;
      line_cnt <= nxt_line;

      // Pattern controls only take effect at a frame boundary.
      if (start_frame) begin
        pat_q <= pattern_sel;
        rgb_q <= solid_rgb;
      end

      vsync      <= (nxt_state == ST_VSYNC);
      href       <= href_nxt;
      data       <= href_nxt ? pix_byte : 8'h00;
      busy       <= (nxt_state != ST_IDLE);
      frame_done <= frame_end_nxt;
      if (frame_end_nxt) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed testbench for cam_stream_gen with a reduced frame geometry:
// LINE = 20 cycles (16 href + 4 blank), frame = 140 cycles
// (vsync 1..20, back porch 21..40, active 41..120, front porch 121..140).

module tb_cam_stream_gen;

  localparam int FRAME     = 140;
  localparam int LINE      = 20;
  localparam int VS_END    = 20;
  localparam int ACT_START = 41;
  localparam int ACT_CYC   = 80;
  localparam int HREF_CYC  = 16;

  logic        pclk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cam_stream_gen #(
    .H_ACTIVE (8),
    .H_BLANK  (4),
    .V_ACTIVE (4),
    .VSYNC_LEN(1),
    .V_BACK   (1),
    .V_FRONT  (1)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .solid_rgb  (solid_rgb),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 pclk = ~pclk;

  // Packed view {vsync, href, data, busy, frame_done, frame_cnt}.
  function automatic logic [19:0] observed();
    return {vsync, href, data, busy, frame_done, frame_cnt};
  endfunction

  // Expected RGB444 pixel; bar width is one pixel with H_ACTIVE = 8.
  function automatic logic [11:0] exp_rgb(input logic [1:0] pat, input logic [11:0] rgb,
                                          input int x, input int y, input int fc);
    logic [11:0] bars [8];
    logic [7:0]  xv;
    logic [7:0]  yv;
    logic [7:0]  fv;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    xv = 8'(x);
    yv = 8'(y);
    fv = 8'(fc);
    case (pat)
      2'd0:    return bars[x];
      2'd1:    return {xv[5:2], yv[5:2], fv[3:0]};
      2'd2:    return rgb;
      default: return (xv[5] ^ yv[5] ^ fv[0]) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Checks one full frame cycle by cycle. Called at the negedge of the cycle
  // before the frame's start edge; returns at the negedge of frame_done.
  task automatic check_frame(input string tag, input int fc, input logic [1:0] pat,
                             input logic [11:0] rgb, input int chg_at,
                             input logic [1:0] chg_pat, input logic [11:0] chg_rgb,
                             input int drop_at);
    int a;
    int col;
    int ln;
    logic        vs;
    logic        hr;
    logic [7:0]  dt;
    logic [11:0] px;
    logic [19:0] expv;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge pclk);
      vs = (c <= VS_END);
      hr = 1'b0;
      dt = 8'h00;
      a  = c - ACT_START;
      if (a >= 0 && a < ACT_CYC) begin
        col = a % LINE;
        ln  = a / LINE;
        if (col < HREF_CYC) begin
          hr = 1'b1;
          px = exp_rgb(pat, rgb, col / 2, ln, fc);
          dt = (col % 2 == 0) ? {4'h0, px[11:8]} : px[7:0];
        end
      end
      expv = {vs, hr, dt, 1'b1, (c == FRAME), (c == FRAME) ? 8'(fc + 1) : 8'(fc)};
      total_cnt++;
      if (observed() !== expv)
        $display("FAIL %s fc%0d cycle %0d: got %h want %h", tag, fc, c, observed(), expv);
      else
        pass_cnt++;
      if (c == chg_at) begin
        pattern_sel = chg_pat;
        solid_rgb   = chg_rgb;
      end
      if (c == drop_at) enable = 1'b0;
    end
  endtask

  // Checks n idle cycles: everything low, frame_cnt holding fc.
  task automatic check_idle(input string tag, input int n, input int fc);
    logic [19:0] expv;
    expv = {12'h000, 8'(fc)};
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      total_cnt++;
      if (observed() !== expv)
        $display("FAIL %s idle cycle %0d: got %h want %h", tag, i, observed(), expv);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    total_cnt++;
    if (observed() !== 20'h0)
      $display("FAIL reset_state: got %h want %h", observed(), 20'h0);
    else
      pass_cnt++;
    rst = 1'b0;
    check_idle("idle_no_enable", 5, 0);
  endtask

  // Colour bars; pattern_sel changed mid-frame must not affect this frame.
  task automatic test_first_frame();
    pattern_sel = 2'd0;
    enable      = 1'b1;
    check_frame("bars", 0, 2'd0, 12'h000, 60, 2'd1, 12'h000, -1);
  endtask

  // Gradient frame directly after the first, no gap cycles.
  task automatic test_back_to_back();
    check_frame("gradient", 1, 2'd1, 12'h000, 70, 2'd2, 12'hABC, -1);
  endtask

  // Solid colour latched per frame: ABC stays until the next frame.
  task automatic test_solid_latch();
    check_frame("solid_abc", 2, 2'd2, 12'hABC, 50, 2'd2, 12'h123, -1);
  endtask

  // enable dropped during ACTIVE: frame completes, then idle.
  task automatic test_enable_drop();
    check_frame("solid_123", 3, 2'd2, 12'h123, -1, 2'd2, 12'h123, 60);
    check_idle("idle_after_drop", 10, 4);
  endtask

  // Reset while href is high aborts at once; re-enable restarts at vsync.
  task automatic test_reset_mid_line();
    pattern_sel = 2'd0;
    enable      = 1'b1;
    repeat (45) @(negedge pclk);
    total_cnt++;
    if ({vsync, href, busy} !== 3'b011)
      $display("FAIL pre_reset_href: got %b want %b", {vsync, href, busy}, 3'b011);
    else
      pass_cnt++;
    rst = 1'b1;
    @(negedge pclk);
    total_cnt++;
    if (observed() !== 20'h0)
      $display("FAIL reset_mid_line: got %h want %h", observed(), 20'h0);
    else
      pass_cnt++;
    rst         = 1'b0;
    pattern_sel = 2'd3;
  endtask

  // 257 checkerboard frames: frame_cnt wraps 255 -> 0 and the colour
  // follows frame_cnt[0] (000 when even, FFF when odd at this size).
  task automatic test_wrap();
    for (int f = 0; f <= 256; f++) begin
      check_frame("checker", f & 255, 2'd3, 12'h000, -1, 2'd3, 12'h000,
                  (f == 256) ? 60 : -1);
    end
    check_idle("idle_after_wrap", 5, 1);
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 12'h000;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_solid_latch();
    test_enable_drop();
    test_reset_mid_line();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
